// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Also holds the frame acceptance rule used at the stop bit.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int FRAME_BITS  = 11;
  localparam int TIMEOUT_50M = 100000;
  localparam int FILTER_LEN  = 8;

  // Odd parity over data+parity and a high stop bit make a frame good
  function automatic logic frame_ok(input logic [7:0] data,
                                    input logic       parity,
                                    input logic       stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Pin synchronisers, PS/2 clock deglitch filter and falling-edge detect.
// The data output is delayed so it lines up with the filtered clock.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER = FILTER_LEN
) (
  input  logic clock50,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat
);

  localparam logic [FILTER-1:0] ALL_ONES  = {FILTER{1'b1}};
  localparam logic [FILTER-1:0] ALL_ZEROS = {FILTER{1'b0}};

  logic [1:0]        clk_sync_r;
  logic [1:0]        dat_sync_r;
  logic [FILTER-1:0] clk_shift_r;
  logic [FILTER-1:0] dat_shift_r;
  logic              filt_clk_r;

  // two-stage synchronisers, idle bus level on reset
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk};
      dat_sync_r <= {dat_sync_r[0], ps2_dat};
    end
  end

  // sample history; data shifts alongside clock so both stay aligned
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      clk_shift_r <= ALL_ONES;
      dat_shift_r <= ALL_ONES;
    end else begin
      clk_shift_r <= {clk_shift_r[FILTER-2:0], clk_sync_r[1]};
      dat_shift_r <= {dat_shift_r[FILTER-2:0], dat_sync_r[1]};
    end
  end

  // filtered clock only changes after FILTER identical samples
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      filt_clk_r <= 1'b1;
    end else if (clk_shift_r == ALL_ZEROS) begin
      filt_clk_r <= 1'b0;
    end else if (clk_shift_r == ALL_ONES) begin
      filt_clk_r <= 1'b1;
    end else begin
      filt_clk_r <= filt_clk_r;
    end
  end

  assign fall = filt_clk_r & (clk_shift_r == ALL_ZEROS);
  assign dat  = dat_shift_r[FILTER-1];

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB-first, odd parity, stop.
// Good bytes strobe ps2_hit; parity, stop and stalled frames strobe ps2_err.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER  = FILTER_LEN,
  parameter int TIMEOUT = TIMEOUT_50M
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_hit,
  output logic       ps2_err,
  output logic       busy
);

  localparam int            TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TC_LAST   = TW'(TIMEOUT - 1);
  localparam int            DATA_BITS = FRAME_BITS - 3;
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic          fall_s;
  logic          dat_s;

  ps2_state_t    state_r,   state_nxt_s;
  logic [2:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]    shreg_r,   shreg_nxt_s;
  logic          parity_r,  parity_nxt_s;
  logic [TW-1:0] tcnt_r,    tcnt_nxt_s;
  logic [7:0]    data_r,    data_nxt_s;
  logic          hit_r,     hit_nxt_s;
  logic          err_r,     err_nxt_s;

  ps2_filter #(
    .FILTER (FILTER)
  ) u_filter (
    .clock50 (clock50),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .fall    (fall_s),
    .dat     (dat_s)
  );

  // next-state, datapath and strobes; a fall always beats the timeout
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shreg_nxt_s   = shreg_r;
    parity_nxt_s  = parity_r;
    tcnt_nxt_s    = tcnt_r;
    data_nxt_s    = data_r;
    hit_nxt_s     = 1'b0;
    err_nxt_s     = 1'b0;

    if (fall_s) begin
      tcnt_nxt_s = {TW{1'b0}};
      case (state_r)
        IDLE: begin
          if (!dat_s) begin
            state_nxt_s   = DATA;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        DATA: begin
          shreg_nxt_s   = {dat_s, shreg_r[7:1]};
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = PARITY;
          end else begin
            state_nxt_s = DATA;
          end
        end
        PARITY: begin
          parity_nxt_s = dat_s;
          state_nxt_s  = STOP;
        end
        STOP: begin
          if (frame_ok(shreg_r, parity_r, dat_s)) begin
            data_nxt_s = shreg_r;
            hit_nxt_s  = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else if ((state_r != IDLE) && (tcnt_r == TC_LAST)) begin
      state_nxt_s = IDLE;
      err_nxt_s   = 1'b1;
      tcnt_nxt_s  = {TW{1'b0}};
    end else if (state_r == IDLE) begin
      tcnt_nxt_s = {TW{1'b0}};
    end else begin
      tcnt_nxt_s = tcnt_r + TW'(1);
    end
  end

  // state and output registers
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= 3'd0;
      shreg_r   <= 8'h00;
      parity_r  <= 1'b0;
      tcnt_r    <= {TW{1'b0}};
      data_r    <= 8'h00;
      hit_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shreg_r   <= shreg_nxt_s;
      parity_r  <= parity_nxt_s;
      tcnt_r    <= tcnt_nxt_s;
      data_r    <= data_nxt_s;
      hit_r     <= hit_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  assign ps2_data = data_r;
  assign ps2_hit  = hit_r;
  assign ps2_err  = err_r;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: frames are built from byte/parity/stop
// values and the expected hits/errors come from the PS/2 framing rules.
module tb_ps2_keyboard;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 40;

  logic       clock50 = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_data;
  logic       ps2_hit;
  logic       ps2_err;
  logic       busy;

  ps2_keyboard #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock50  (clock50),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .ps2_data (ps2_data),
    .ps2_hit  (ps2_hit),
    .ps2_err  (ps2_err),
    .busy     (busy)
  );

  always #5 clock50 = ~clock50;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // observed strobes
  logic [7:0] hit_q[$];
  int hit_cnt       = 0;
  int err_cnt       = 0;
  int err_cyc       = 0;
  int low_since_hit = 0;
  int last_gap      = 0;
  int last_fall_cyc = 0;

  // reference model
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int exp_errs = 0;

  initial forever begin
    @(posedge clock50);
    cyc++;
  end

  initial forever begin
    @(negedge clock50);
    if (ps2_hit === 1'b1) begin
      hit_q.push_back(ps2_data);
      hit_cnt++;
      last_gap = low_since_hit;
      low_since_hit = 0;
    end
    if (ps2_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (busy === 1'b0) low_since_hit++;
  end

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic bit good_frame(input logic [7:0] d, input logic par, input logic stp);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(par);
    return (stp == 1'b1) && (ones % 2 == 1);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock50);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stp);
    if (good_frame(d, par, stp)) begin
      exp_q.push_back(d);
      exp_data = d;
    end else begin
      exp_errs++;
    end
  endtask

  task automatic start_test();
    hit_q.delete();
    exp_q.delete();
    hit_cnt  = 0;
    err_cnt  = 0;
    exp_errs = 0;
  endtask

  // drives the first nbits of a frame; optional glitch in each high phase
  task automatic send_bits(input logic [7:0] d, input logic par, input logic stp,
                           input int nbits, input bit glitch);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      wait_cycles(HALF / 2);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
      if (glitch) begin
        wait_cycles(15);
        ps2_clk = 1'b0;
        wait_cycles(5);
        ps2_clk = 1'b1;
        wait_cycles(HALF / 2 - 20);
      end else begin
        wait_cycles(HALF / 2);
      end
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input bit glitch);
    send_bits(d, par, stp, 11, glitch);
    model_frame(d, par, stp);
  endtask

  task automatic compare_results(input string name);
    checks++;
    if (hit_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_hits: got %0d hits, expected %0d", name, hit_q.size(), exp_q.size());
    end
    for (int i = 0; i < hit_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (hit_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_byte%0d: got %h expected %h", name, i, hit_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_cnt !== exp_errs) begin
      failures++;
      $display("FAIL %s_errs: got %0d expected %0d", name, err_cnt, exp_errs);
    end
    checks++;
    if (ps2_data !== exp_data) begin
      failures++;
      $display("FAIL %s_data: got %h expected %h", name, ps2_data, exp_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if ({ps2_data, ps2_hit, ps2_err, busy} !== 11'h000) begin
      failures++;
      $display("FAIL reset_in: got %h expected 000", {ps2_data, ps2_hit, ps2_err, busy});
    end
    reset = 1'b0;
    wait_cycles(20);
    checks++;
    if ({ps2_data, ps2_hit, ps2_err, busy} !== 11'h000) begin
      failures++;
      $display("FAIL reset_out: got %h expected 000", {ps2_data, ps2_hit, ps2_err, busy});
    end
  endtask

  task automatic test_single_frame();
    start_test();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    compare_results("single");
  endtask

  task automatic test_back_to_back();
    start_test();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
    compare_results("b2b");
    checks++;
    if (last_gap < 1) begin
      failures++;
      $display("FAIL b2b_busy_gap: got %0d low cycles, expected >= 1", last_gap);
    end
  endtask

  task automatic test_parity_error();
    start_test();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    compare_results("parity_bad");
    send_frame(8'h12, odd_par(8'h12), 1'b1, 1'b0);
    compare_results("parity_next");
  endtask

  task automatic test_stop_error();
    start_test();
    send_frame(8'h3A, odd_par(8'h3A), 1'b0, 1'b0);
    compare_results("stop_bad");
  endtask

  task automatic test_timeout();
    int waited;
    int delta;
    start_test();
    send_bits(8'hA5, 1'b0, 1'b1, 6, 1'b0);
    waited = 0;
    while (err_cnt == 0 && waited < 1500) begin
      wait_cycles(1);
      waited++;
    end
    delta = err_cyc - last_fall_cyc;
    checks++;
    if (err_cnt !== 1) begin
      failures++;
      $display("FAIL timeout_err: got %0d errors, expected 1", err_cnt);
    end
    checks++;
    if (delta < 1000 || delta > 1025) begin
      failures++;
      $display("FAIL timeout_delay: got %0d cycles, expected 1000..1025", delta);
    end
    wait_cycles(2);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy: got %b expected 0", busy);
    end
    exp_errs = 1;
    send_frame(8'h59, odd_par(8'h59), 1'b1, 1'b0);
    compare_results("timeout_next");
  endtask

  task automatic test_glitch();
    start_test();
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      wait_cycles(5);
      ps2_clk = 1'b1;
      wait_cycles(30);
    end
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b1);
    compare_results("glitch");
  endtask

  task automatic test_reset_mid_frame();
    start_test();
    send_bits(8'h1C, 1'b0, 1'b1, 5, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy_before: got %b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ps2_data, ps2_hit, ps2_err, busy} !== 11'h000) begin
      failures++;
      $display("FAIL midreset_async: got %h expected 000", {ps2_data, ps2_hit, ps2_err, busy});
    end
    exp_data = 8'h00;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(20);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
    compare_results("midreset");
  endtask

  task automatic test_random();
    logic [7:0] d;
    int r;
    start_test();
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 7));
      send_frame(d, odd_par(d) ^ (r == 0), (r == 1) ? 1'b0 : 1'b1, 1'b0);
    end
    compare_results("random");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_error();
    test_stop_error();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
